// File: rtl/robo_atuador.sv
// robo_atuador: turns level commands into fixed-length motor/claw pulses
// and keeps step, heading and removal odometry.
module robo_atuador #(
  parameter int WIDTH_CNT = 8,
  parameter int T_AVANCO  = 4,
  parameter int T_GIRO    = 6,
  parameter int T_REMOCAO = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        avancar,
  input  logic        girar,
  input  logic        remover,
  output logic        motor_frente,
  output logic        motor_giro,
  output logic        garra,
  output logic        ocupado,
  output logic        concluido,
  output logic [15:0] passos,
  output logic [1:0]  direcao,
  output logic [7:0]  remocoes
);

  typedef enum logic [1:0] {
    OCIOSO,
    AVANCO,
    GIRO,
    REMOCAO
  } estado_t;

  localparam logic [WIDTH_CNT-1:0] LD_A =
    WIDTH_CNT'(T_AVANCO - 1);
  localparam logic [WIDTH_CNT-1:0] LD_G =
    WIDTH_CNT'(T_GIRO - 1);
  localparam logic [WIDTH_CNT-1:0] LD_R =
    WIDTH_CNT'(T_REMOCAO - 1);

  estado_t              estado_q;
  estado_t              estado_d;
  logic [WIDTH_CNT-1:0] cnt_q;
  logic [WIDTH_CNT-1:0] cnt_d;
  logic                 fim;

  logic sel_r;
  logic sel_g;
  logic sel_a;

  logic        frente_d;
  logic        giro_d;
  logic        garra_d;
  logic        ocupado_d;
  logic [15:0] passos_d;
  logic [1:0]  direcao_d;
  logic [7:0]  remocoes_d;

  // one-hot command select: remover beats girar beats avancar
  assign sel_r = remover;
  assign sel_g = girar & ~remover;
  assign sel_a = avancar & ~girar & ~remover;

  // state and duration counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
    end
  end

  // next state: accept a command when idle, count down when active
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    fim      = 1'b0;
    unique case (estado_q)
      OCIOSO: begin
        unique case (1'b1)
          sel_r: begin
            estado_d = REMOCAO;
            cnt_d    = LD_R;
          end
          sel_g: begin
            estado_d = GIRO;
            cnt_d    = LD_G;
          end
          sel_a: begin
            estado_d = AVANCO;
            cnt_d    = LD_A;
          end
          default: ;
        endcase
      end
      default: begin
        if (cnt_q == '0) begin
          estado_d = OCIOSO;
          fim      = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  // next output values: drives follow the next state, odometry on finish
  always_comb begin
    frente_d   = (estado_d == AVANCO);
    giro_d     = (estado_d == GIRO);
    garra_d    = (estado_d == REMOCAO);
    ocupado_d  = (estado_d != OCIOSO);
    passos_d   = passos;
    direcao_d  = direcao;
    remocoes_d = remocoes;
    if (fim) begin
      unique case (estado_q)
        AVANCO: begin
          if (passos != 16'hFFFF)
            passos_d = passos + 16'd1;
        end
        GIRO: direcao_d = direcao + 2'd1;
        REMOCAO: begin
          if (remocoes != 8'hFF)
            remocoes_d = remocoes + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // registered outputs so nothing reaches a pin combinationally
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      motor_frente <= 1'b0;
      motor_giro   <= 1'b0;
      garra        <= 1'b0;
      ocupado      <= 1'b0;
      concluido    <= 1'b0;
      passos       <= '0;
      direcao      <= '0;
      remocoes     <= '0;
    end else begin
      motor_frente <= frente_d;
      motor_giro   <= giro_d;
      garra        <= garra_d;
      ocupado      <= ocupado_d;
      concluido    <= fim;
      passos       <= passos_d;
      direcao      <= direcao_d;
      remocoes     <= remocoes_d;
    end
  end

endmodule

// File: tb/tb_robo_atuador.sv
// tb_robo_atuador: vector table, directed corner cases and random
// stimulus against a pulse-duration reference model.
module tb_robo_atuador;

  localparam int TA = 4;
  localparam int TG = 6;
  localparam int TR = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        avancar = 1'b0;
  logic        girar = 1'b0;
  logic        remover = 1'b0;
  logic        motor_frente;
  logic        motor_giro;
  logic        garra;
  logic        ocupado;
  logic        concluido;
  logic [15:0] passos;
  logic [1:0]  direcao;
  logic [7:0]  remocoes;

  logic        s_av = 1'b0;
  logic        s_gi = 1'b0;
  logic        s_re = 1'b0;
  logic        s_fr;
  logic        s_mg;
  logic        s_ga;
  logic        s_oc;
  logic        s_co;
  logic [15:0] s_pa;
  logic [1:0]  s_di;
  logic [7:0]  s_rm;

  int n_chk = 0;
  int n_fail = 0;

  robo_atuador dut (
    .clock        (clock),
    .reset        (reset),
    .avancar      (avancar),
    .girar        (girar),
    .remover      (remover),
    .motor_frente (motor_frente),
    .motor_giro   (motor_giro),
    .garra        (garra),
    .ocupado      (ocupado),
    .concluido    (concluido),
    .passos       (passos),
    .direcao      (direcao),
    .remocoes     (remocoes)
  );

  robo_atuador #(
    .T_AVANCO  (1),
    .T_GIRO    (1),
    .T_REMOCAO (1)
  ) dut1 (
    .clock        (clock),
    .reset        (reset),
    .avancar      (s_av),
    .girar        (s_gi),
    .remover      (s_re),
    .motor_frente (s_fr),
    .motor_giro   (s_mg),
    .garra        (s_ga),
    .ocupado      (s_oc),
    .concluido    (s_co),
    .passos       (s_pa),
    .direcao      (s_di),
    .remocoes     (s_rm)
  );

  always #5 clock = ~clock;

  // reference model: what action is running and how many cycles remain
  int m_act = 0;
  int m_left = 0;
  int m_done = 0;
  int m_p = 0;
  int m_d = 0;
  int m_r = 0;

  task automatic model_reset();
    m_act = 0; m_left = 0; m_done = 0;
    m_p = 0; m_d = 0; m_r = 0;
  endtask

  task automatic model_edge(input logic a, input logic g,
                            input logic r);
    m_done = 0;
    if (m_act != 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (m_act == 1) m_p = (m_p < 65535) ? m_p + 1 : m_p;
        if (m_act == 2) m_d = (m_d + 1) % 4;
        if (m_act == 3) m_r = (m_r < 255) ? m_r + 1 : m_r;
        m_act = 0;
        m_done = 1;
      end
    end else if (r) begin
      m_act = 3; m_left = TR;
    end else if (g) begin
      m_act = 2; m_left = TG;
    end else if (a) begin
      m_act = 1; m_left = TA;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] drv_now();
    return {motor_frente, motor_giro, garra, ocupado, concluido};
  endfunction

  task automatic cmp_model(input string nm);
    logic [4:0] e;
    e = {m_act == 1, m_act == 2, m_act == 3,
         m_act != 0, m_done != 0};
    chk({nm, "_drv"}, 32'(drv_now()), 32'(e));
    chk({nm, "_passos"}, 32'(passos), 32'(m_p));
    chk({nm, "_dir"}, 32'(direcao), 32'(m_d));
    chk({nm, "_rem"}, 32'(remocoes), 32'(m_r));
  endtask

  task automatic step(input logic a, input logic g, input logic r,
                      input string nm);
    avancar = a; girar = g; remover = r;
    @(posedge clock);
    model_edge(a, g, r);
    #1;
    cmp_model(nm);
  endtask

  task automatic step1(input logic a, input logic g, input logic r);
    s_av = a; s_gi = g; s_re = r;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [2:0]  cmd;
    logic [4:0]  drv;
    logic [15:0] p;
    logic [1:0]  d;
    logic [7:0]  rm;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [2:0] c, input logic [4:0] dv,
                     input logic [15:0] p, input logic [7:0] rm);
    vec_t v;
    v.cmd = c; v.drv = dv; v.p = p; v.d = 2'd0; v.rm = rm;
    vq.push_back(v);
  endtask

  initial begin
    int dirs[5];
    int p0;
    int pulses;
    dirs = '{1, 2, 3, 0, 1};

    // cmd = {remover, girar, avancar}
    // drv = {frente, giro, garra, ocupado, concluido}
    add(3'b001, 5'b10010, 16'd0, 8'd0);
    for (int i = 0; i < 3; i++)
      add(3'b000, 5'b10010, 16'd0, 8'd0);
    add(3'b000, 5'b00001, 16'd1, 8'd0);
    for (int i = 0; i < 10; i++)
      add(3'b111, 5'b00110, 16'd1, 8'd0);
    add(3'b000, 5'b00001, 16'd1, 8'd1);
    add(3'b000, 5'b00000, 16'd1, 8'd1);

    #12;
    chk("reset_drv", 32'(drv_now()), 32'd0);
    chk("reset_cnt", {passos, direcao, remocoes, 6'd0}, 32'd0);
    reset = 1'b1;

    foreach (vq[i]) begin
      step(vq[i].cmd[0], vq[i].cmd[1], vq[i].cmd[2], "tbl_m");
      chk("tbl_drv", 32'(drv_now()), 32'(vq[i].drv));
      chk("tbl_passos", 32'(passos), 32'(vq[i].p));
      chk("tbl_dir", 32'(direcao), 32'(vq[i].d));
      chk("tbl_rem", 32'(remocoes), 32'(vq[i].rm));
    end

    for (int n = 0; n < 5; n++) begin
      for (int c = 0; c < 6; c++) begin
        step(0, 1, 0, "hold_m");
        chk("hold_giro_on", 32'(motor_giro), 32'd1);
      end
      step(0, 1, 0, "hold_m");
      chk("hold_giro_gap", 32'(motor_giro), 32'd0);
      chk("hold_done", 32'(concluido), 32'd1);
      chk("hold_dir", 32'(direcao), 32'(dirs[n]));
    end
    step(0, 0, 0, "hold_m");

    p0 = int'(passos);
    step(0, 1, 0, "glitch_m");
    step(1, 0, 0, "glitch_m");
    step(1, 0, 0, "glitch_m");
    for (int i = 0; i < 4; i++) step(0, 0, 0, "glitch_m");
    chk("glitch_done", 32'(concluido), 32'd1);
    chk("glitch_passos", 32'(passos), 32'(p0));
    chk("glitch_dir", 32'(direcao), 32'd2);
    step(0, 0, 0, "glitch_m");
    chk("glitch_no_fwd", 32'(motor_frente), 32'd0);

    step(0, 0, 1, "abort_m");
    step(0, 0, 0, "abort_m");
    step(0, 0, 0, "abort_m");
    chk("abort_pre_garra", 32'(garra), 32'd1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("abort_drv", 32'(drv_now()), 32'd0);
    chk("abort_rem", 32'(remocoes), 32'd0);
    chk("abort_cnt", 32'({passos, direcao}), 32'd0);
    #3 reset = 1'b1;
    step(1, 0, 0, "after_abort_m");
    chk("after_abort_fwd", 32'(motor_frente), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, "after_abort_m");
    chk("after_abort_passos", 32'(passos), 32'd1);

    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 6) == 0, "rand");
    end
    step(0, 0, 0, "rand");

    step1(0, 1, 0);
    chk("t1_giro", 32'({s_mg, s_oc, s_co}), 32'b110);
    step1(0, 0, 0);
    chk("t1_done", 32'({s_mg, s_oc, s_co}), 32'b001);
    chk("t1_dir", 32'(s_di), 32'd1);
    step1(0, 0, 0);
    pulses = 0;
    for (int i = 0; i < 520; i++) begin
      step1(0, 0, 1);
      if (s_co) begin
        pulses++;
        chk("sat_rem", 32'(s_rm),
            32'((pulses < 255) ? pulses : 255));
      end
      if (s_co && s_oc) chk("sat_busy_done", 32'(s_oc), 32'd0);
    end
    step1(0, 0, 0);
    chk("sat_pulses", 32'(pulses), 32'd260);
    chk("sat_rem_final", 32'(s_rm), 32'hFF);
    chk("sat_other", 32'({s_pa, s_fr}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/robo_atuador.md
# robo_atuador

Actuator sequencer that sits directly downstream of the wall-following robot controller. It consumes the controller's level commands `avancar`, `girar` and `remover` and converts each accepted command into a fixed-length, registered motor or claw pulse. It reports a busy/done handshake and keeps odometry: step count, heading modulo 4 and removal count. The controller's outputs connect directly to this block's command inputs with no glue logic.

## Interface

Parameters:
- `WIDTH_CNT`, 8: width of the duration down-counter.
- `T_AVANCO`, 4: cycles the forward motor stays on per accepted advance (1..2^WIDTH_CNT).
- `T_GIRO`, 6: cycles the rotation motor stays on per accepted 90° turn (1..2^WIDTH_CNT).
- `T_REMOCAO`, 10: cycles the claw stays on per accepted removal (1..2^WIDTH_CNT).

Ports:
- `clock` in 1: single clock; everything is on the rising edge.
- `reset` in 1: asynchronous, active-low. Logic 0 resets the block immediately; release is synchronous to `clock`.
- `avancar` in 1: advance command (level).
- `girar` in 1: rotate command (level).
- `remover` in 1: remove-obstacle command (level).
- `motor_frente` out 1: forward motor drive.
- `motor_giro` out 1: rotation motor drive.
- `garra` out 1: claw drive.
- `ocupado` out 1: an action is in progress; commands are ignored while this is 1.
- `concluido` out 1: one-cycle pulse when an action finishes.
- `passos` out 16: completed advances, saturating at 0xFFFF.
- `direcao` out 2: heading, 0..3, incremented per completed rotation, wraps 3→0.
- `remocoes` out 8: completed removals, saturating at 0xFF.

## Operation

- States: `OCIOSO`, `AVANCO`, `GIRO`, `REMOCAO`. The reset state is `OCIOSO`.
- Reset value of every output is 0. `reset`=0 mid-action aborts the action at once. The aborted action is not counted and no `concluido` pulse is issued.
- In `OCIOSO`, commands are sampled every edge, with priority `remover` > `girar` > `avancar`:
  - The highest-priority asserted command moves the FSM to its state.
  - The down-counter loads T−1 for that action.
  - Lower-priority commands asserted in the same cycle are dropped, not queued.
- In an action state:
  - Exactly one drive output is 1: `motor_frente` for `AVANCO`, `motor_giro` for `GIRO`, `garra` for `REMOCAO`.
  - `ocupado`=1.
  - The counter decrements each edge.
  - On the edge where the counter equals 0, the FSM returns to `OCIOSO`, sets `concluido`=1 for one cycle and updates the matching odometry register.
- Command inputs are ignored in action states, including changes and glitches.
- Odometry:
  - `passos` increments by 1 per completed `AVANCO` and holds at 0xFFFF.
  - `direcao` increments modulo 4 per completed `GIRO`.
  - `remocoes` increments per completed `REMOCAO` and holds at 0xFF.
- All outputs are registered. No output depends combinationally on the inputs.

## Timing

- Command sampled high in `OCIOSO` at edge k: the drive output and `ocupado` are 1 from after edge k through edge k+T; they fall after edge k+T.
- The drive output is high for exactly T cycles.
- `concluido` and the odometry update become visible after edge k+T, in the first `OCIOSO` cycle.
- That same `OCIOSO` cycle samples commands. A command held continuously therefore gives a period of T+1 cycles: T active, 1 idle. `concluido` and the new acceptance coincide.
- With T=1, the action lasts one cycle: the counter loads 0 and the FSM returns on the next edge.
- At most one drive output is high in any cycle.
- `ocupado` is never high in the same cycle as `concluido`.
- Asserting `reset` forces all outputs to 0 without waiting for a clock edge.

## Test plan

- Reset, then `avancar`=1 for one cycle at edge k:
  - `motor_frente`=1 exactly for cycles k+1..k+4.
  - `concluido` pulses at k+5.
  - `passos`=1; `direcao`=0; `remocoes`=0.
- `avancar`, `girar` and `remover` all asserted together in `OCIOSO`:
  - only `garra` pulses, for 10 cycles;
  - `remocoes`=1, `passos`=0, `direcao`=0.
- `girar` held high for 5 actions:
  - `motor_giro` shows five 6-cycle pulses separated by single low cycles;
  - `direcao` sequence is 1, 2, 3, 0, 1.
- `avancar` pulsed during cycles 2–3 of an active `GIRO`:
  - the pulse is ignored; `passos` stays 0;
  - only the `GIRO` completes.
- `reset` driven to 0 during cycle 3 of `REMOCAO`:
  - `garra`, `ocupado` and `concluido` are 0 immediately; `remocoes` is 0;
  - after release, the FSM is in `OCIOSO` and accepts the next command.
- Preload scenario (override `T_AVANCO`=1 and issue 65 537 advances):
  - `passos` reaches 0xFFFF and holds;
  - `concluido` still pulses for every action.
